// File: rtl/vedic_seq_mul16_pkg.sv
// Shared definitions for the sequential 16x16 Vedic multiplier.
// Holds the FSM state encoding, the accumulate shift amounts for each
// partial-product step, and the operand/result widths.
package vedic_seq_mul16_pkg;

  localparam int OPW  = 16;
  localparam int RESW = 32;

  localparam int SH0  = 0;
  localparam int SH8  = 8;
  localparam int SH16 = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step 0 is lo*lo, steps 1 and 2 are the cross terms, step 3 is hi*hi.
  function automatic logic [4:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    return 5'(SH0);
      2'd3:    return 5'(SH16);
      default: return 5'(SH8);
    endcase
  endfunction

endpackage

// File: rtl/vedic_seq_mul16_vedic8x8.sv
// vedic8x8: combinational 8x8 unsigned multiplier, Urdhva-Tiryagbhyam style.
// Built recursively: 2x2 cells -> 4x4 blocks -> 8x8, each level combining
// the vertical (lo*lo, hi*hi) and crosswise (lo*hi, hi*lo) products.
// Ports:
//   i_a  [7:0]   multiplicand
//   i_b  [7:0]   multiplier
//   o_p  [15:0]  product
module vedic8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);

  function automatic logic [3:0] v2x2(input logic [1:0] x, input logic [1:0] y);
    logic t_x, t_y, t_z, t_c;
    logic [3:0] r;
    t_x  = x[1] & y[0];
    t_y  = x[0] & y[1];
    t_z  = x[1] & y[1];
    t_c  = t_x & t_y;
    r[0] = x[0] & y[0];
    r[1] = t_x ^ t_y;
    r[2] = t_z ^ t_c;
    r[3] = t_z & t_c;
    return r;
  endfunction

  function automatic logic [7:0] v4x4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    logic [5:0] mid;
    q0  = v2x2(x[1:0], y[1:0]);
    q1  = v2x2(x[3:2], y[1:0]);
    q2  = v2x2(x[1:0], y[3:2]);
    q3  = v2x2(x[3:2], y[3:2]);
    // Crosswise terms plus the carry-out of the low vertical term.
    mid = {2'b0, q1} + {2'b0, q2} + {4'b0, q0[3:2]};
    return {({q3, 2'b00} + mid), q0[1:0]};
  endfunction

  logic [7:0]  w_q0, w_q1, w_q2, w_q3;
  logic [11:0] w_mid;

  assign w_q0  = v4x4(i_a[3:0], i_b[3:0]);
  assign w_q1  = v4x4(i_a[7:4], i_b[3:0]);
  assign w_q2  = v4x4(i_a[3:0], i_b[7:4]);
  assign w_q3  = v4x4(i_a[7:4], i_b[7:4]);
  assign w_mid = {4'b0, w_q1} + {4'b0, w_q2} + {8'b0, w_q0[7:4]};
  assign o_p   = {({w_q3, 4'b0000} + w_mid), w_q0[3:0]};

endmodule

// File: rtl/vedic_seq_mul16.sv
// vedic_seq_mul16: sequential 16x16 multiplier reusing one vedic8x8 array.
// Operands are latched on accept, split into bytes, and the four partial
// products are shift-accumulated over four cycles into a 32-bit result.
//
// State table:
//   state   | meaning
//   ST_IDLE | waiting for an operand pair, o_in_ready=1
//   ST_MUL  | one partial product per cycle, r_step 0..3
//   ST_DONE | o_out_valid=1, o_prod held until i_out_ready
//
// Parameter EARLY_ZERO: a zero operand skips ST_MUL and returns 0.
// Macro VEDIC_SEQ_SIGNED_EN: operands are two's complement; magnitudes are
// multiplied and the sign is applied when the result is loaded.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   operand pair valid
//   o_in_ready   operands can be accepted (ST_IDLE only)
//   i_a, i_b     16-bit operands
//   o_out_valid  o_prod valid
//   i_out_ready  downstream accepts o_prod
//   o_prod       32-bit product
//   o_busy       high in ST_MUL or ST_DONE
module vedic_seq_mul16
  import vedic_seq_mul16_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [OPW-1:0]  i_a,
  input  logic [OPW-1:0]  i_b,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [RESW-1:0] o_prod,
  output logic            o_busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_step;
  logic [RESW-1:0]   r_acc;
  logic [OPW-1:0]    r_a_q;
  logic [OPW-1:0]    r_b_q;
  logic [RESW-1:0]   r_prod;
`ifdef VEDIC_SEQ_SIGNED_EN
  logic              r_neg_q;
`endif

  logic              w_accept;
  logic              w_zero;
  logic [OPW-1:0]    w_a_mag;
  logic [OPW-1:0]    w_b_mag;
  logic [7:0]        w_op_a;
  logic [7:0]        w_op_b;
  logic [15:0]       w_pp;
  logic [RESW-1:0]   w_pp_sh;
  logic [RESW-1:0]   w_acc_nxt;

  assign w_zero = (i_a == '0) || (i_b == '0);

`ifdef VEDIC_SEQ_SIGNED_EN
  // 0x8000 negates to itself, which read unsigned is the required 32768.
  assign w_a_mag = i_a[OPW-1] ? (~i_a + 16'd1) : i_a;
  assign w_b_mag = i_b[OPW-1] ? (~i_b + 16'd1) : i_b;
`else
  assign w_a_mag = i_a;
  assign w_b_mag = i_b;
`endif

  // step[1] picks the a byte, step[0] picks the b byte.
  assign w_op_a = r_step[1] ? r_a_q[15:8] : r_a_q[7:0];
  assign w_op_b = r_step[0] ? r_b_q[15:8] : r_b_q[7:0];

  vedic8x8 u_vedic8x8 (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_p (w_pp)
  );

  assign w_pp_sh   = {16'b0, w_pp} << step_shift(r_step);
  assign w_acc_nxt = r_acc + w_pp_sh;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (EARLY_ZERO && w_zero) ? ST_DONE : ST_MUL;
        end
      end
      ST_MUL: begin
        o_busy = 1'b1;
        if (r_step == 2'd3) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_acc   <= '0;
      r_a_q   <= '0;
      r_b_q   <= '0;
      r_prod  <= '0;
`ifdef VEDIC_SEQ_SIGNED_EN
      r_neg_q <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a_q  <= w_a_mag;
            r_b_q  <= w_b_mag;
            r_acc  <= '0;
            r_step <= '0;
`ifdef VEDIC_SEQ_SIGNED_EN
            r_neg_q <= i_a[OPW-1] ^ i_b[OPW-1];
`endif
            if (EARLY_ZERO && w_zero) r_prod <= '0;
          end
        end
        ST_MUL: begin
          r_acc  <= w_acc_nxt;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
`ifdef VEDIC_SEQ_SIGNED_EN
            r_prod <= r_neg_q ? (~w_acc_nxt + 32'd1) : w_acc_nxt;
`else
            r_prod <= w_acc_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_prod = r_prod;

endmodule

// File: tb/tb_vedic_seq_mul16.sv
// Testbench for vedic_seq_mul16: two instances (EARLY_ZERO=1 and 0),
// directed cases plus randomized operand pairs against a plain-arithmetic
// product model.
module tb_vedic_seq_mul16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [31:0] prod      [2];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  vedic_seq_mul16 #(.EARLY_ZERO(1'b1)) u_dut_ez (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .i_a(a), .i_b(b), .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
    .o_prod(prod[0]), .o_busy(busy[0])
  );

  vedic_seq_mul16 #(.EARLY_ZERO(1'b0)) u_dut_nz (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .i_a(a), .i_b(b), .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
    .o_prod(prod[1]), .o_busy(busy[1])
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
`ifdef VEDIC_SEQ_SIGNED_EN
    int sp;
    sp = int'($signed(x)) * int'($signed(y));
    return 32'(sp);
`else
    return {16'b0, x} * {16'b0, y};
`endif
  endfunction

  // One full transaction on DUT d. Inputs change on the falling edge and
  // outputs are sampled there too. Cycle count 0 is the accept cycle.
  task automatic run_op(input int d, input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] exp_p, input int hold, input bit noise,
                        input string tag);
    int cyc, bad, exp_lat;
    logic [31:0] p0;
    exp_lat = (d == 0 && (x == 16'd0 || y == 16'd0)) ? 1 : 5;
    @(negedge clk);
    a = x; b = y;
    in_valid[d]  = 1'b1;
    out_ready[d] = (hold == 0);
    chk_val({tag, ".in_ready"}, 32'(in_ready[d]), 32'd1);
    @(negedge clk);
    cyc = 1; bad = 0;
    in_valid[d] = noise;
    a = 16'($urandom); b = 16'($urandom);
    while (out_valid[d] !== 1'b1 && cyc < 20) begin
      if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) bad++;
      @(negedge clk);
      cyc++;
      a = 16'($urandom); b = 16'($urandom);
    end
    in_valid[d] = 1'b0;
    chk_val({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    chk_val({tag, ".prod"}, prod[d], exp_p);
    p0 = prod[d];
    for (int i = 0; i < hold; i++) begin
      if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) bad++;
      @(negedge clk);
      if (out_valid[d] !== 1'b1 || prod[d] !== p0) bad++;
    end
    if (in_ready[d] !== 1'b0) bad++;
    chk_val({tag, ".busy_hold"}, 32'(bad), 32'd0);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk_val({tag, ".release"}, {29'd0, out_valid[d], in_ready[d], busy[d]}, 32'b010);
  endtask

  initial begin
    logic [15:0] x, y;
    int rises;
    rst = 1'b1; a = '0; b = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_val($sformatf("reset%0d.ready", i), 32'(in_ready[i]), 32'd1);
      chk_val($sformatf("reset%0d.valid_busy", i), {30'd0, out_valid[i], busy[i]}, 32'd0);
      chk_val($sformatf("reset%0d.prod", i), prod[i], 32'd0);
    end

    run_op(0, 16'h1234, 16'h5678, 32'h06260060, 0, 1'b0, "dir_1234x5678");
`ifdef VEDIC_SEQ_SIGNED_EN
    run_op(0, 16'hFFFF, 16'hFFFF, 32'h00000001, 0, 1'b1, "dir_ffffxffff");
`else
    run_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b1, "dir_ffffxffff");
`endif
    run_op(0, 16'h0000, 16'hABCD, 32'h0, 0, 1'b0, "dir_zero_ez");
    run_op(1, 16'h0000, 16'hABCD, 32'h0, 0, 1'b0, "dir_zero_noez");
    run_op(0, 16'h00FF, 16'h0100, 32'h0000FF00, 7, 1'b0, "dir_hold");
    run_op(0, 16'h0002, 16'h0007, 32'd14, 0, 1'b0, "dir_after_hold");

    // Reset in the middle of a multiply: the pair must vanish.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_val("midrst.ready", 32'(in_ready[0]), 32'd1);
    chk_val("midrst.prod", prod[0], 32'd0);
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0] === 1'b1) rises++;
      @(negedge clk);
    end
    chk_val("midrst.no_valid", 32'(rises), 32'd0);
    out_ready[0] = 1'b0;
    run_op(0, 16'd3, 16'd5, 32'd15, 0, 1'b0, "midrst.next");

`ifdef VEDIC_SEQ_SIGNED_EN
    run_op(0, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 0, 1'b0, "sgn_m1x2");
    run_op(0, 16'h8000, 16'h8000, 32'h40000000, 0, 1'b0, "sgn_minxmin");
    run_op(1, 16'h8000, 16'h0003, 32'hFFFE8000, 1, 1'b0, "sgn_minx3");
`endif

    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 5) == 0) x = 16'd0;
      if ($urandom_range(0, 7) == 0) y = 16'd0;
      if ($urandom_range(0, 5) == 0) x = 16'h8000;
      run_op(i % 4 == 3 ? 1 : 0, x, y, ref_prod(x, y), $urandom_range(0, 3),
             1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
